// File: rtl/mem_refill_responder.sv
// mem_refill_responder
//   Memory-side responder for a cache controller's refill port. A line read
//   returns 2**WORD_OFFSET acked beats, critical word first and wrapping
//   within the line. A single-word write is stored on the capture edge and
//   acked for one cycle. The backing store is a word-addressed array that
//   reset does not clear.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   req_cc2mem   request valid, held until completion is seen
//   rdwr_cc2mem  0 = line refill, 1 = single-word write
//   adr_cc2mem   byte address (bits [1:0] ignored, high bits alias)
//   dat_cc2mem   write data
//   ack_mem2cc   beat valid (read) / write done
//   dat_mem2cc   beat data (0 whenever ack is low)
//   word_mem2cc  word index within the line of the current beat
//   busy         high whenever the responder is not idle
module mem_refill_responder #(
  parameter int ADR_WIDTH      = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORD_OFFSET    = 2,
  parameter int LATENCY        = 3,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_cc2mem,
  input  logic                   rdwr_cc2mem,
  input  logic [ADR_WIDTH-1:0]   adr_cc2mem,
  input  logic [DATA_WIDTH-1:0]  dat_cc2mem,
  output logic                   ack_mem2cc,
  output logic [DATA_WIDTH-1:0]  dat_mem2cc,
  output logic [WORD_OFFSET-1:0] word_mem2cc,
  output logic                   busy
);

  localparam int DEPTH  = 1 << MEM_DEPTH_LOG2;
  localparam int BEATS  = 1 << WORD_OFFSET;
  localparam int LINE_W = MEM_DEPTH_LOG2 - WORD_OFFSET;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  // One extra bit so the counter can reach BEATS, marking "all beats sent".
  localparam int CNT_W  = WORD_OFFSET + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_BURST,
    S_WACK,
    S_DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic [LINE_W-1:0]       line_reg, line_next;
  logic [WORD_OFFSET-1:0]  crit_reg, crit_next;
  logic [LAT_W-1:0]        lat_reg, lat_next;
  logic [CNT_W-1:0]        beat_reg, beat_next;
  logic                    ack_reg, ack_next;
  logic [WORD_OFFSET-1:0]  word_reg, word_next;
  logic                    busy_reg, busy_next;
  logic [DATA_WIDTH-1:0]   dat_reg;

  // Read strobe and word for the beat presented at the coming edge.
  logic                    rd_en;
  logic [WORD_OFFSET-1:0]  rd_word;
  logic                    mem_we;

  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

  logic [MEM_DEPTH_LOG2-1:0] wr_idx;
  logic [MEM_DEPTH_LOG2-1:0] rd_idx;

  // Address bits outside the store index are deliberately ignored.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{adr_cc2mem[ADR_WIDTH-1:MEM_DEPTH_LOG2+2], adr_cc2mem[1:0]};

  assign wr_idx = adr_cc2mem[MEM_DEPTH_LOG2+1:2];
  assign rd_idx = {line_reg, rd_word};

  always_comb begin
    state_next = state_reg;
    line_next  = line_reg;
    crit_next  = crit_reg;
    lat_next   = lat_reg;
    beat_next  = beat_reg;
    ack_next   = 1'b0;
    word_next  = '0;
    rd_en      = 1'b0;
    rd_word    = '0;
    mem_we     = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        if (req_cc2mem) begin
          if (rdwr_cc2mem) begin
            mem_we     = 1'b1;
            ack_next   = 1'b1;
            state_next = S_WACK;
          end else begin
            line_next = adr_cc2mem[MEM_DEPTH_LOG2+1:WORD_OFFSET+2];
            crit_next = adr_cc2mem[WORD_OFFSET+1:2];
            beat_next = '0;
            lat_next  = LAT_W'(LATENCY - 1);
            // With a single cycle of latency there is nothing to count:
            // BURST presents beat 0 on the very next edge.
            if (LATENCY == 1) state_next = S_BURST;
            else              state_next = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (lat_reg == '0) begin
          // The edge that ends the wait already carries beat 0.
          rd_en      = 1'b1;
          rd_word    = crit_reg;
          ack_next   = 1'b1;
          word_next  = crit_reg;
          beat_next  = CNT_W'(1);
          state_next = S_BURST;
        end else begin
          lat_next = lat_reg - 1'b1;
        end
      end

      S_BURST: begin
        if (beat_reg == CNT_W'(BEATS)) begin
          state_next = S_DONE;
        end else begin
          // Word index wraps naturally in WORD_OFFSET bits.
          rd_en      = 1'b1;
          rd_word    = crit_reg + beat_reg[WORD_OFFSET-1:0];
          ack_next   = 1'b1;
          word_next  = crit_reg + beat_reg[WORD_OFFSET-1:0];
          beat_next  = beat_reg + 1'b1;
        end
      end

      S_WACK: begin
        state_next = S_DONE;
      end

      S_DONE: begin
        // Requiring req low here stops a held request from retriggering.
        if (!req_cc2mem) state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    busy_next = (state_next != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      line_reg  <= '0;
      crit_reg  <= '0;
      lat_reg   <= '0;
      beat_reg  <= '0;
      ack_reg   <= 1'b0;
      word_reg  <= '0;
      busy_reg  <= 1'b0;
      dat_reg   <= '0;
    end else begin
      state_reg <= state_next;
      line_reg  <= line_next;
      crit_reg  <= crit_next;
      lat_reg   <= lat_next;
      beat_reg  <= beat_next;
      ack_reg   <= ack_next;
      word_reg  <= word_next;
      busy_reg  <= busy_next;
      // Registered read; data is forced to zero on any non-beat cycle.
      dat_reg   <= rd_en ? mem[rd_idx] : '0;
    end
  end

  // Backing store has no reset so contents survive it. The write is gated
  // by rst so a request held through reset cannot alter the store.
  always_ff @(posedge clk) begin
    if (mem_we && rst) begin
      mem[wr_idx] <= dat_cc2mem;
    end
  end

  assign ack_mem2cc  = ack_reg;
  assign dat_mem2cc  = dat_reg;
  assign word_mem2cc = word_reg;
  assign busy        = busy_reg;

endmodule
